// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller.
// Opcodes, field positions, FSM states and the instruction decoder.
package alu_pkg;

    localparam int BIT_WIDTH    = 16;
    localparam int OPCODE_WIDTH = 8;
    localparam int FLAG_WIDTH   = 5;
    localparam int NUM_REGS     = 16;
    localparam int ADDR_WIDTH   = 4;
    localparam int IMM_WIDTH    = 8;

    localparam int OP_LSB   = 12;
    localparam int RD_LSB   = 8;
    localparam int EXT_LSB  = 4;
    localparam int RS_LSB   = 0;

    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_C = 0;

    localparam logic [7:0] OP_NOP  = 8'b0000_0000;
    localparam logic [7:0] OP_AND  = 8'b0000_0001;
    localparam logic [7:0] OP_OR   = 8'b0000_0010;
    localparam logic [7:0] OP_XOR  = 8'b0000_0011;
    localparam logic [7:0] OP_NOT  = 8'b0000_0100;
    localparam logic [7:0] OP_ADD  = 8'b0000_0101;
    localparam logic [7:0] OP_ADDU = 8'b0000_0110;
    localparam logic [7:0] OP_ADDC = 8'b0000_0111;
    localparam logic [7:0] OP_SUB  = 8'b0000_1001;
    localparam logic [7:0] OP_CMP  = 8'b0000_1011;
    localparam logic [7:0] OP_LSH  = 8'b1000_0100;
    localparam logic [7:0] OP_ARSH = 8'b1000_0110;

    localparam logic [3:0] OPH_ADDI  = 4'b0101;
    localparam logic [3:0] OPH_ADDUI = 4'b0110;
    localparam logic [3:0] OPH_ADDCI = 4'b0111;
    localparam logic [3:0] OPH_SUBI  = 4'b1001;
    localparam logic [3:0] OPH_CMPI  = 4'b1011;
    localparam logic [3:0] OPH_SHIFT = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_COMMIT
    } state_t;

    typedef struct packed {
        logic legal;
        logic use_reg;
        logic sext;
        logic wr_reg;
        logic wr_psr;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] w);
        dec_t       d;
        logic [7:0] opc;
        opc = {w[OP_LSB +: 4], w[EXT_LSB +: 4]};
        d   = '0;
        casez (opc)
            OP_NOP:
                d = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_ADD, OP_ADDU, OP_ADDC, OP_SUB,
            OP_LSH, OP_ARSH:
                d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            OP_CMP:
                d = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
            {OPH_ADDI, 4'b????}, {OPH_ADDUI, 4'b????},
            {OPH_ADDCI, 4'b????}, {OPH_SUBI, 4'b????}:
                d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
            {OPH_CMPI, 4'b????}:
                d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
            // LSHI/ARSHI/RSH/RSHI: ext 000x, 001x, 100x, 101x
            {OPH_SHIFT, 4'b?0??}:
                d = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            default:
                d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_reg_file.sv
// Register file: two synchronous read ports, one write port,
// one asynchronous debug read port, cleared by reset.
module alu_reg_file
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [BIT_WIDTH-1:0]  rd_data_a,
    output logic [BIT_WIDTH-1:0]  rd_data_b,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BIT_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [BIT_WIDTH-1:0]  dbg_data
);

    logic [BIT_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            if (we) begin
                regs[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_data_a <= regs[rd_addr_a];
                rd_data_b <= regs[rd_addr_b];
            end
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/decode front end for the combinational ALU: one instruction
// in flight, IDLE -> READ -> EXEC -> COMMIT, then result and flags commit.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [15:0]             instr,
    output logic [BIT_WIDTH-1:0]    alu_rsrc_imm,
    output logic [BIT_WIDTH-1:0]    alu_rdest,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    input  logic [BIT_WIDTH-1:0]    alu_result,
    input  logic [FLAG_WIDTH-1:0]   alu_flags,
    output logic [FLAG_WIDTH-1:0]   psr,
    output logic                    wb_valid,
    output logic [ADDR_WIDTH-1:0]   wb_addr,
    output logic [BIT_WIDTH-1:0]    wb_data,
    output logic                    illegal,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    output logic [BIT_WIDTH-1:0]    dbg_data
);

    state_t                state;
    logic [15:0]           ir;
    logic [BIT_WIDTH-1:0]  res_q;
    logic [FLAG_WIDTH-1:0] flg_q;
    logic                  commit_reg;
    logic                  commit_psr;
    logic [BIT_WIDTH-1:0]  rd_a;
    logic [BIT_WIDTH-1:0]  rd_b;
    logic [BIT_WIDTH-1:0]  src_val;
    logic                  accept;
    logic                  we;
    dec_t                  dec;

    assign accept = instr_valid && instr_ready;
    assign we     = (state == S_COMMIT) && commit_reg;
    assign dec    = decode(ir);

    // Read ports are addressed straight from the bus so data is ready in READ
    alu_reg_file u_rf (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (accept),
        .rd_addr_a (instr[RD_LSB +: ADDR_WIDTH]),
        .rd_addr_b (instr[RS_LSB +: ADDR_WIDTH]),
        .rd_data_a (rd_a),
        .rd_data_b (rd_b),
        .we        (we),
        .wr_addr   (ir[RD_LSB +: ADDR_WIDTH]),
        .wr_data   (res_q),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always_comb begin
        src_val = '0;
        if (dec.use_reg) begin
            src_val = rd_b;
        end else if (dec.sext) begin
            src_val = {{(BIT_WIDTH-IMM_WIDTH){ir[IMM_WIDTH-1]}},
                       ir[IMM_WIDTH-1:0]};
        end else begin
            src_val = {{(BIT_WIDTH-4){1'b0}}, ir[RS_LSB +: 4]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            instr_ready  <= 1'b1;
            ir           <= '0;
            alu_rsrc_imm <= '0;
            alu_rdest    <= '0;
            alu_opcode   <= '0;
            res_q        <= '0;
            flg_q        <= '0;
            commit_reg   <= 1'b0;
            commit_psr   <= 1'b0;
            psr          <= '0;
            wb_valid     <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            illegal      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        ir          <= instr;
                        instr_ready <= 1'b0;
                        state       <= S_READ;
                    end
                end
                S_READ: begin
                    commit_reg <= dec.wr_reg;
                    commit_psr <= dec.wr_psr;
                    if (!dec.legal) begin
                        illegal     <= 1'b1;
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        alu_rdest    <= rd_a;
                        alu_rsrc_imm <= src_val;
                        alu_opcode   <= {ir[OP_LSB +: 4], ir[EXT_LSB +: 4]};
                        state        <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q <= alu_result;
                    flg_q <= alu_flags;
                    state <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (commit_psr) begin
                        psr <= flg_q;
                    end
                    if (commit_reg) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= ir[RD_LSB +: ADDR_WIDTH];
                        wb_data  <= res_q;
                    end
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
